// File: rtl/fb_write_arbiter.sv
// Merges NUM_PORTS pixel-write channels, each behind a small FIFO, into one framebuffer write port (round-robin).
// Latency: a strobe in cycle T to an idle channel is presented on fb_wr_* in cycle T+2.
// Backpressure: fb_wr_ready=0 holds the output register; full FIFOs raise in_full. Macro FB_ARB_BOUNDS_CHECK_EN drops off-screen writes.
module fb_write_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int XW             = $clog2(RESOLUTION_X),
    parameter int YW             = $clog2(RESOLUTION_Y),
    parameter int VW             = $clog2(PALETTE_LENGTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    in_wr_en,
    input  logic [NUM_PORTS*XW-1:0] in_pxl_x,
    input  logic [NUM_PORTS*YW-1:0] in_pxl_y,
    input  logic [NUM_PORTS*VW-1:0] in_pxl_value,
    output logic [NUM_PORTS-1:0]    in_full,
    output logic [NUM_PORTS-1:0]    overflow,
    output logic                    fb_wr_en,
    output logic [XW-1:0]           fb_wr_pxl_x,
    output logic [YW-1:0]           fb_wr_pxl_y,
    output logic [VW-1:0]           fb_wr_pxl_value,
    input  logic                    fb_wr_ready,
    output logic [15:0]             drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int DW = XW + YW + VW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DW-1:0]        mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr [NUM_PORTS];
    logic [AW-1:0]        rd_ptr [NUM_PORTS];
    logic [AW:0]          occ [NUM_PORTS];
    logic [NUM_PORTS-1:0] push, pop, drop, empty;
    logic [PW-1:0]        rr, grant;
    logic                 grant_vld, load;
    int                   idx;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            in_full[p] = (occ[p] == DEPTH_C);
            empty[p]   = (occ[p] == '0);
        end
    end

`ifdef FB_ARB_BOUNDS_CHECK_EN
    always_comb begin
        drop = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop[p] = in_wr_en[p] &&
                      !(({1'b0, in_pxl_x[p*XW +: XW]} < (XW+1)'(RESOLUTION_X)) &&
                        ({1'b0, in_pxl_y[p*YW +: YW]} < (YW+1)'(RESOLUTION_Y)));
        end
    end
`else
    always_comb drop = '0;
`endif

    // A write seen while full is refused even if the same edge pops the channel.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            push[p] = in_wr_en[p] && !in_full[p] && !drop[p];
    end

    assign load = !fb_wr_en || fb_wr_ready;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant     = PW'(idx);
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            pop[p] = load && grant_vld && (grant == PW'(p));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                occ[p]    <= '0;
            end
            rr              <= '0;
            overflow        <= '0;
            fb_wr_en        <= 1'b0;
            fb_wr_pxl_x     <= '0;
            fb_wr_pxl_y     <= '0;
            fb_wr_pxl_value <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) begin
                    mem[p][wr_ptr[p]] <= {in_pxl_x[p*XW +: XW], in_pxl_y[p*YW +: YW],
                                          in_pxl_value[p*VW +: VW]};
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                end
                if (pop[p])
                    rd_ptr[p] <= rd_ptr[p] + 1'b1;
                occ[p] <= occ[p] + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
                if (in_wr_en[p] && in_full[p] && !drop[p])
                    overflow[p] <= 1'b1;
            end
            if (load) begin
                fb_wr_en <= grant_vld;
                if (grant_vld) begin
                    {fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value} <= mem[grant][rd_ptr[grant]];
                    rr <= (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
                end
            end
        end
    end

`ifdef FB_ARB_BOUNDS_CHECK_EN
    logic [4:0]  n_drop;
    logic [16:0] drop_sum;

    always_comb begin
        n_drop = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            n_drop = n_drop + 5'(drop[p]);
    end

    assign drop_sum = {1'b0, drop_count} + 17'(n_drop);

    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: latency vectors from a table, then round-robin, overflow, stall and mid-run reset sequences.
module tb_fb_write_arbiter;
    localparam int NP = 4;
`ifdef FB_ARB_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [7:0] v;
    } pix_t;

    typedef struct {
        int ch;
        int x;
        int y;
        int v;
        bit exp_en;
        int exp_x;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] in_wr_en;
    logic [NP*9-1:0] in_pxl_x;
    logic [NP*9-1:0] in_pxl_y;
    logic [NP*8-1:0] in_pxl_value;
    logic [NP-1:0] in_full;
    logic [NP-1:0] overflow;
    logic          fb_wr_en;
    logic [8:0]    fb_wr_pxl_x;
    logic [8:0]    fb_wr_pxl_y;
    logic [7:0]    fb_wr_pxl_value;
    logic          fb_wr_ready;
    logic [15:0]   drop_count;

    fb_write_arbiter #(
        .NUM_PORTS(NP), .FIFO_DEPTH(4),
        .RESOLUTION_X(400), .RESOLUTION_Y(300), .PALETTE_LENGTH(256)
    ) dut (
        .clk(clk), .reset(reset),
        .in_wr_en(in_wr_en), .in_pxl_x(in_pxl_x), .in_pxl_y(in_pxl_y),
        .in_pxl_value(in_pxl_value), .in_full(in_full), .overflow(overflow),
        .fb_wr_en(fb_wr_en), .fb_wr_pxl_x(fb_wr_pxl_x), .fb_wr_pxl_y(fb_wr_pxl_y),
        .fb_wr_pxl_value(fb_wr_pxl_value), .fb_wr_ready(fb_wr_ready),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    pix_t exp_q[$];
    pix_t cur;
    pix_t hold_pix;
    bit   hold_prev = 1'b0;

    assign cur = {fb_wr_pxl_x, fb_wr_pxl_y, fb_wr_pxl_value};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic pix_t mk(int x, int y, int v);
        return {9'(x), 9'(y), 8'(v)};
    endfunction

    // Scoreboard consumer and hold-stability watcher, sampled on the falling edge.
    always @(negedge clk) begin
        pix_t e;
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_en", 32'(fb_wr_en), 32'd1);
                check("hold_pix", 32'(cur), 32'(hold_pix));
            end
            if (fb_wr_en && fb_wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'(cur), 32'(e));
                end
            end
            hold_prev = fb_wr_en && !fb_wr_ready;
            hold_pix  = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(int ch, pix_t p);
        in_wr_en[ch]             = 1'b1;
        in_pxl_x[ch*9 +: 9]      = p.x;
        in_pxl_y[ch*9 +: 9]      = p.y;
        in_pxl_value[ch*8 +: 8]  = p.v;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_wr_en = '0;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    vec_t vecs[5];
    int   exp_drop;
    int   sent;
    bit   pat[4];

    initial begin
        vecs[0] = '{ch: 0, x: 10,  y: 20,  v: 5,   exp_en: 1'b1, exp_x: 10};
        vecs[1] = '{ch: 3, x: 399, y: 299, v: 255, exp_en: 1'b1, exp_x: 399};
        vecs[2] = '{ch: 2, x: 0,   y: 0,   v: 0,   exp_en: 1'b1, exp_x: 0};
        vecs[3] = '{ch: 1, x: 400, y: 0,   v: 7,   exp_en: !BC,  exp_x: 400};
        vecs[4] = '{ch: 1, x: 5,   y: 300, v: 9,   exp_en: !BC,  exp_x: 5};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; in_wr_en = '0; in_pxl_x = '0; in_pxl_y = '0; in_pxl_value = '0;
        fb_wr_ready = 1'b1;
        repeat (3) tick();
        check("rst_en", 32'(fb_wr_en), 32'd0);
        check("rst_full", 32'(in_full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_x", 32'(fb_wr_pxl_x), 32'd0);
        check("rst_y", 32'(fb_wr_pxl_y), 32'd0);
        check("rst_v", 32'(fb_wr_pxl_value), 32'd0);
        reset = 1'b0;

        // Single-write latency vectors, including the off-screen cases.
        exp_drop = 0;
        for (int i = 0; i < 5; i++) begin
            fb_wr_ready = 1'b1;
            set_wr(vecs[i].ch, mk(vecs[i].x, vecs[i].y, vecs[i].v));
            if (vecs[i].exp_en) exp_q.push_back(mk(vecs[i].exp_x, vecs[i].y, vecs[i].v));
            else exp_drop++;
            tick();
            in_wr_en = '0;
            check("lat_t1_en", 32'(fb_wr_en), 32'd0);
            tick();
            check("lat_t2_en", 32'(fb_wr_en), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                check("lat_x", 32'(fb_wr_pxl_x), 32'(vecs[i].exp_x));
                check("lat_y", 32'(fb_wr_pxl_y), 32'(vecs[i].y));
                check("lat_v", 32'(fb_wr_pxl_value), 32'(vecs[i].v));
            end
            tick();
            check("lat_t3_en", 32'(fb_wr_en), 32'd0);
            check("drop_count", 32'(drop_count), 32'(exp_drop));
        end
        check("vec_drained", 32'(exp_q.size()), 32'd0);
        check("vec_ovf", 32'(overflow), 32'd0);

        // All channels at once, twice: second round proves the pointer wrapped to 0.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NP; c++) begin
                set_wr(c, mk(c*10 + r, c + 100, 8'h30 + c));
                exp_q.push_back(mk(c*10 + r, c + 100, 8'h30 + c));
            end
            tick();
            in_wr_en = '0;
            for (int c = 0; c < NP; c++) begin
                tick();
                check("rr_en", 32'(fb_wr_en), 32'd1);
                check("rr_x", 32'(fb_wr_pxl_x), 32'(c*10 + r));
            end
            tick();
            check("rr_idle", 32'(fb_wr_en), 32'd0);
        end

        // Fill channel 1 behind a stalled output register, then overflow it.
        do_reset();
        fb_wr_ready = 1'b0;
        set_wr(0, mk(1, 1, 1));
        exp_q.push_back(mk(1, 1, 1));
        tick();
        in_wr_en = '0;
        tick();
        check("stall_en", 32'(fb_wr_en), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            set_wr(1, mk(50 + k, 60, 8'h10 + k));
            if (k <= 4) exp_q.push_back(mk(50 + k, 60, 8'h10 + k));
            tick();
            in_wr_en = '0;
            check("fill_full", 32'(in_full), (k >= 4) ? 32'h2 : 32'h0);
            check("fill_ovf", 32'(overflow), (k == 5) ? 32'h2 : 32'h0);
        end
        fb_wr_ready = 1'b1;
        repeat (8) tick();
        check("fill_drained", 32'(exp_q.size()), 32'd0);
        check("fill_unfull", 32'(in_full), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'h2);

        // Channel 2 streams against a 1,0,0,1 ready pattern, stalling on in_full.
        do_reset();
        sent = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            fb_wr_ready = pat[cyc % 4];
            in_wr_en = '0;
            if (sent < 10 && !in_full[2]) begin
                set_wr(2, mk(200 + sent, 7, sent));
                exp_q.push_back(mk(200 + sent, 7, sent));
                sent++;
            end
            tick();
        end
        in_wr_en = '0;
        fb_wr_ready = 1'b1;
        repeat (10) tick();
        check("stream_sent", 32'(sent), 32'd10);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three entries queued and a pixel held on the output.
        do_reset();
        fb_wr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_wr(3, mk(300 + k, 9, 8'hA0 + k));
            tick();
        end
        in_wr_en = '0;
        check("pre_rst_en", 32'(fb_wr_en), 32'd1);
        reset = 1'b1;
        set_wr(0, mk(77, 77, 77));
        tick();
        in_wr_en = '0;
        check("mid_rst_en", 32'(fb_wr_en), 32'd0);
        check("mid_rst_full", 32'(in_full), 32'd0);
        check("mid_rst_x", 32'(fb_wr_pxl_x), 32'd0);
        reset = 1'b0;
        fb_wr_ready = 1'b1;
        repeat (8) tick();
        check("post_rst_en", 32'(fb_wr_en), 32'd0);
        check("post_rst_q", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
